// File: rtl/uart_pkg.sv
// Purpose: shared UART constants, frame levels and FSM encoding for TX and RX.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package uart_pkg;

  localparam int CLK_FREQ_DEFAULT = 50_000_000;
  localparam int BAUD_DEFAULT     = 9600;
  localparam int DATA_BITS        = 8;

  // Line levels of the framing bits; the line idles at the stop level.
  localparam logic START_BIT = 1'b0;
  localparam logic STOP_BIT  = 1'b1;

  // Frame-position encoding, common to transmitter and receiver.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } uart_state_e;

endpackage

// File: rtl/uart_tx_fifo_top_if.sv
// Purpose: byte-wide valid/ready handshake into the UART transmitter.
// Latency: n/a (wiring only).
// Backpressure: source holds tx_data while tx_valid is high and tx_ready is low.
interface uart_tx_fifo_top_if;
  import uart_pkg::*;

  logic [DATA_BITS-1:0] tx_data;
  logic                 tx_valid;
  logic                 tx_ready;

  modport master (output tx_data, output tx_valid, input tx_ready);
  modport slave  (input tx_data, input tx_valid, output tx_ready);

endinterface

// File: rtl/uart_tx_fifo.sv
// Purpose: synchronous FIFO with the head entry readable combinationally.
// Latency: a push is visible at the head (and in full/empty) one cycle later.
// Backpressure: caller must not push when full nor pop when empty.
module uart_tx_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  // The extra MSB distinguishes a wrapped (full) pointer pair from an equal (empty) one.
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;

  assign rdata = mem[rd_ptr[AW-1:0]];
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

  // Storage array; contents need no reset because the pointers gate visibility.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr[AW-1:0]] <= wdata;
    end
  end

  // Pointer update; reset empties the FIFO by re-aligning the pointers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

endmodule

// File: rtl/uart_tx_fifo_top.sv
// Purpose: buffered 8N1 UART transmitter with internal baud divider.
// Latency: write at cycle W pops at W+1, start bit on txd from W+2, frame is 10*BAUD_DIV cycles.
// Backpressure: tx_ready = !full; back-to-back frames drain the FIFO without idle gaps.
module uart_tx_fifo_top
  import uart_pkg::*;
#(
  parameter int CLK_FREQ   = CLK_FREQ_DEFAULT,
  parameter int BAUD       = BAUD_DEFAULT,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  uart_tx_fifo_top_if.slave   tx_if,
  output logic                txd,
  output logic                busy,
  output logic                tx_done
);

  localparam int BAUD_DIV = CLK_FREQ / BAUD;
  localparam int CW       = $clog2(BAUD_DIV);
  localparam int BW       = $clog2(DATA_BITS);
  localparam logic [CW-1:0] CNT_MAX  = CW'(BAUD_DIV - 1);
  localparam logic [BW-1:0] BIT_LAST = BW'(DATA_BITS - 1);

  uart_state_e          state, state_nxt;
  logic [CW-1:0]        baud_cnt, cnt_nxt;
  logic [BW-1:0]        bit_cnt, bit_nxt;
  logic [DATA_BITS-1:0] shift, shift_nxt;
  logic                 txd_nxt;
  logic                 done_nxt;
  logic                 bit_end;

  logic                 fifo_push;
  logic                 fifo_pop;
  logic                 fifo_full;
  logic                 fifo_empty;
  logic [DATA_BITS-1:0] fifo_rdata;

  assign tx_if.tx_ready = !fifo_full;
  assign fifo_push      = tx_if.tx_valid && !fifo_full;
  assign bit_end        = (baud_cnt == CNT_MAX);

  uart_tx_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (DATA_BITS)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (fifo_push),
    .wdata (tx_if.tx_data),
    .pop   (fifo_pop),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // Next-state, counters and next line level; txd/busy/tx_done are registered from these.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = baud_cnt;
    bit_nxt   = bit_cnt;
    shift_nxt = shift;
    txd_nxt   = txd;
    fifo_pop  = 1'b0;
    unique case (state)
      IDLE: begin
        cnt_nxt = '0;
        txd_nxt = STOP_BIT;
        if (!fifo_empty) begin
          fifo_pop  = 1'b1;
          shift_nxt = fifo_rdata;
          bit_nxt   = '0;
          state_nxt = START;
          txd_nxt   = START_BIT;
        end
      end
      START: begin
        if (bit_end) begin
          cnt_nxt   = '0;
          state_nxt = DATA;
          txd_nxt   = shift[0];
        end else begin
          cnt_nxt = baud_cnt + 1'b1;
        end
      end
      DATA: begin
        if (bit_end) begin
          cnt_nxt   = '0;
          shift_nxt = shift >> 1;
          if (bit_cnt == BIT_LAST) begin
            bit_nxt   = '0;
            state_nxt = STOP;
            txd_nxt   = STOP_BIT;
          end else begin
            bit_nxt = bit_cnt + 1'b1;
            // Level of the next data bit, i.e. shift[0] after this shift.
            txd_nxt = shift[1];
          end
        end else begin
          cnt_nxt = baud_cnt + 1'b1;
        end
      end
      STOP: begin
        if (bit_end) begin
          cnt_nxt = '0;
          if (!fifo_empty) begin
            // Chain straight into the next frame to keep the line contiguous.
            fifo_pop  = 1'b1;
            shift_nxt = fifo_rdata;
            bit_nxt   = '0;
            state_nxt = START;
            txd_nxt   = START_BIT;
          end else begin
            state_nxt = IDLE;
            txd_nxt   = STOP_BIT;
          end
        end else begin
          cnt_nxt = baud_cnt + 1'b1;
        end
      end
      default: begin
        state_nxt = IDLE;
        txd_nxt   = STOP_BIT;
      end
    endcase
    // Pulse is registered, so it is armed one cycle ahead of the last stop cycle.
    done_nxt = (state_nxt == STOP) && (cnt_nxt == CNT_MAX);
  end

  // State, datapath and registered outputs; reset abandons any frame and idles the line.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      baud_cnt <= '0;
      bit_cnt  <= '0;
      shift    <= '0;
      txd      <= STOP_BIT;
      busy     <= 1'b0;
      tx_done  <= 1'b0;
    end else begin
      state    <= state_nxt;
      baud_cnt <= cnt_nxt;
      bit_cnt  <= bit_nxt;
      shift    <= shift_nxt;
      txd      <= txd_nxt;
      busy     <= (state_nxt != IDLE);
      tx_done  <= done_nxt;
    end
  end

endmodule

// File: tb/tb_uart_tx_fifo_top.sv
// Purpose: directed self-checking bench for uart_tx_fifo_top at BAUD_DIV = 10.
// Latency: n/a.
// Backpressure: stimulus holds tx_valid until tx_ready is seen.
module tb_uart_tx_fifo_top;

  localparam int CLK_FREQ = 1_000_000;
  localparam int BAUD     = 100_000;
  localparam int MAXC     = 4096;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic txd, busy, tx_done;

  uart_tx_fifo_top_if bus ();

  uart_tx_fifo_top #(
    .CLK_FREQ   (CLK_FREQ),
    .BAUD       (BAUD),
    .FIFO_DEPTH (4)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .tx_if   (bus),
    .txd     (txd),
    .busy    (busy),
    .tx_done (tx_done)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic txd_log  [MAXC];
  logic busy_log [MAXC];
  logic done_log [MAXC];
  logic rdy_log  [MAXC];

  // Record outputs mid-cycle, indexed by the cycle they belong to.
  always @(negedge clk) begin
    if (cyc < MAXC) begin
      txd_log[cyc]  = txd;
      busy_log[cyc] = busy;
      done_log[cyc] = tx_done;
      rdy_log[cyc]  = bus.tx_ready;
    end
  end

  int n_checks = 0;
  int n_fail   = 0;
  logic [7:0] pat [8];
  int acc [8];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic next();
    @(posedge clk);
    #1;
  endtask

  task automatic goto(input int n);
    while (cyc < n) next();
  endtask

  // Offer pat[0..n-1] in order; acc[i] gets the cycle byte i was accepted.
  task automatic send_stream(input int n);
    int i;
    int budget;
    i = 0;
    budget = 0;
    while (i < n && budget < 1000) begin
      bus.tx_data  = pat[i];
      bus.tx_valid = 1'b1;
      @(negedge clk);
      if (bus.tx_ready) begin
        acc[i] = cyc;
        i++;
      end
      next();
      budget++;
    end
    bus.tx_valid = 1'b0;
    check("stream_accepted", i, n);
  endtask

  function automatic int count_val(input int sel, input int lo, input int hi, input logic v);
    int c;
    logic x;
    c = 0;
    for (int i = lo; i <= hi; i++) begin
      case (sel)
        0:       x = txd_log[i];
        1:       x = busy_log[i];
        default: x = done_log[i];
      endcase
      if (x === v) c++;
    end
    return c;
  endfunction

  // Compare 100 logged cycles against the ideal 8N1 waveform of byte b.
  task automatic frame_check(input int s, input logic [7:0] b, input string tag);
    int bad;
    logic [9:0] fr;
    logic [7:0] dec;
    fr  = {1'b1, b, 1'b0};
    bad = 0;
    for (int k = 0; k < 100; k++) begin
      if (txd_log[s + k] !== fr[k / 10]) bad++;
    end
    check({tag, "_wave"}, bad, 0);
    for (int j = 0; j < 8; j++) dec[j] = txd_log[s + 10 * (j + 1) + 5];
    check({tag, "_byte"}, dec, b);
    check({tag, "_done"}, done_log[s + 99], 1);
  endtask

  initial begin
    int w;
    int r;
    bus.tx_valid = 1'b0;
    bus.tx_data  = 8'h00;
    rst_n = 1'b0;
    repeat (3) next();
    check("rst_txd", txd, 1);
    check("rst_busy", busy, 0);
    check("rst_done", tx_done, 0);
    check("rst_ready", bus.tx_ready, 1);
    rst_n = 1'b1;
    repeat (3) next();
    check("idle_txd", txd, 1);

    // Single byte 0xA5
    pat[0] = 8'hA5;
    send_stream(1);
    w = acc[0];
    goto(w + 130);
    frame_check(w + 2, 8'hA5, "a5");
    check("a5_pre_txd", txd_log[w + 1], 1);
    check("a5_pre_busy", busy_log[w + 1], 0);
    check("a5_busy_first", busy_log[w + 2], 1);
    check("a5_busy_cycles", count_val(1, w, w + 129, 1'b1), 100);
    check("a5_busy_after", busy_log[w + 102], 0);
    check("a5_done_count", count_val(2, w, w + 129, 1'b1), 1);

    // Burst of 6 bytes with tx_valid held high
    for (int i = 0; i < 6; i++) pat[i] = 8'(i);
    send_stream(6);
    w = acc[0];
    check("burst_fifth_acc", acc[4] - w, 4);
    check("burst_full_ready", rdy_log[w + 5], 0);
    check("burst_sixth_acc", acc[5] - w, 102);
    goto(w + 620);
    for (int k = 0; k < 6; k++) frame_check(w + 2 + 100 * k, 8'(k), "burst");
    check("burst_busy_cycles", count_val(1, w + 2, w + 601, 1'b1), 600);
    check("burst_busy_after", busy_log[w + 602], 0);
    check("burst_done_count", count_val(2, w, w + 619, 1'b1), 6);

    // Data extremes 0x00 then 0xFF
    pat[0] = 8'h00;
    pat[1] = 8'hFF;
    send_stream(2);
    w = acc[0];
    goto(w + 220);
    frame_check(w + 2, 8'h00, "zero");
    frame_check(w + 102, 8'hFF, "ones");
    check("zero_low_cycles", count_val(0, w + 2, w + 101, 1'b0), 90);
    check("ones_low_cycles", count_val(0, w + 102, w + 201, 1'b0), 10);

    // Push exactly on the STOP->START pop cycle with 3 entries queued
    pat[0] = 8'h11; pat[1] = 8'h22; pat[2] = 8'h33; pat[3] = 8'h44;
    send_stream(4);
    w = acc[0];
    goto(w + 101);
    pat[0] = 8'h55;
    send_stream(1);
    check("simul_push_cycle", acc[0] - w, 101);
    goto(w + 103);
    pat[0] = 8'h66;
    send_stream(1);
    check("simul_push2_cycle", acc[0] - w, 103);
    goto(w + 620);
    check("simul_ready_kept", rdy_log[w + 102], 1);
    check("simul_then_full", rdy_log[w + 104], 0);
    for (int k = 0; k < 6; k++) frame_check(w + 2 + 100 * k, 8'(8'h11 * (k + 1)), "order");
    check("order_busy_cycles", count_val(1, w + 2, w + 601, 1'b1), 600);

    // Reset during data bit 3 of 0x3C with 2 bytes queued
    pat[0] = 8'h3C; pat[1] = 8'h5A; pat[2] = 8'h69;
    send_stream(3);
    w = acc[0];
    goto(w + 45);
    check("mid_busy", busy, 1);
    check("mid_bit3", txd, 1);
    check("mid_bit1", txd_log[w + 25], 0);
    rst_n = 1'b0;
    #1;
    check("arst_txd", txd, 1);
    check("arst_busy", busy, 0);
    check("arst_done", tx_done, 0);
    check("arst_ready", bus.tx_ready, 1);
    repeat (3) next();
    rst_n = 1'b1;
    r = cyc;
    goto(r + 201);
    check("post_rst_low", count_val(0, r, r + 200, 1'b0), 0);
    check("post_rst_busy", count_val(1, r, r + 200, 1'b1), 0);
    check("post_rst_done", count_val(2, r, r + 200, 1'b1), 0);

    // tx_valid pulsed while full
    pat[0] = 8'h81; pat[1] = 8'h42; pat[2] = 8'h24; pat[3] = 8'h18; pat[4] = 8'hC3;
    send_stream(5);
    w = acc[0];
    check("full_fill_acc", acc[4] - w, 4);
    goto(w + 20);
    bus.tx_data  = 8'hEE;
    bus.tx_valid = 1'b1;
    @(negedge clk);
    check("full_ready_low", bus.tx_ready, 0);
    next();
    bus.tx_valid = 1'b0;
    goto(w + 560);
    frame_check(w + 2, 8'h81, "full0");
    frame_check(w + 102, 8'h42, "full1");
    frame_check(w + 202, 8'h24, "full2");
    frame_check(w + 302, 8'h18, "full3");
    frame_check(w + 402, 8'hC3, "full4");
    check("full_done_count", count_val(2, w, w + 559, 1'b1), 5);
    check("full_busy_after", busy_log[w + 502], 0);
    check("full_line_idle", count_val(0, w + 502, w + 559, 1'b0), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
